// File: rtl/ones_pattern_gen.sv
// Thermometer pattern generator: latches a count of ones, presents it in parallel
// and streams it out LSB first, followed by a one-cycle done pulse.
module ones_pattern_gen #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] count_in,
    output logic [W-1:0]  d_out,
    output logic          bit_out,
    output logic          bit_valid,
    output logic          busy,
    output logic          done,
    output logic          sat,
    output logic [CW-1:0] ones_sent
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam logic [CW-1:0] WMAX = CW'(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] idx_q;
    logic [CW-1:0] ones_q;
    logic [W-1:0]  dout_q;
    logic          bit_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;
    logic          sat_q;

    logic          sat_d;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] idx_d;
    logic [W-1:0]  therm_d;

    always_comb begin
        sat_d   = (count_in > WMAX);
        cnt_d   = sat_d ? WMAX : count_in;
        idx_d   = idx_q + CW'(1);
        therm_d = '0;
        for (int i = 0; i < W; i++) begin
            therm_d[i] = (CW'(i) < cnt_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ones_q  <= '0;
            dout_q  <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    bit_q   <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        cnt_q   <= cnt_d;
                        sat_q   <= sat_d;
                        dout_q  <= therm_d;
                        idx_q   <= '0;
                        ones_q  <= '0;
                        // First serial bit is presented on the cycle right after accept
                        bit_q   <= (cnt_d != '0);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_q) begin
                        ones_q <= ones_q + CW'(1);
                    end
                    if (idx_q == LAST) begin
                        valid_q <= 1'b0;
                        bit_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_d;
                        bit_q <= (idx_d < cnt_q);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign d_out     = dout_q;
    assign bit_out   = bit_q;
    assign bit_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sat       = sat_q;
    assign ones_sent = ones_q;

endmodule

// File: doc/ones_pattern_gen.md
ONES_PATTERN_GEN -- requirements
Module: ones_pattern_gen

Interface
REQ-001 Parameter W, default 8: pattern width in bits.
REQ-002 Parameter CW, default 4: count width; SHALL equal ceil(log2(W+1)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request strobe, sampled only in IDLE.
REQ-006 count_in  input  CW  requested number of ones, 0..W.
REQ-007 d_out  output  W  parallel thermometer pattern, bits [count-1:0] set.
REQ-008 bit_out  output  1  serial pattern bit, LSB first.
REQ-009 bit_valid  output  1  high on each cycle bit_out carries a pattern bit.
REQ-010 busy  output  1  high in SHIFT and DONE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 sat  output  1  count_in exceeded W on the accepted request; held until next accept.
REQ-013 ones_sent  output  CW  running count of ones emitted on bit_out in the current job.

Function
REQ-014 FSM states: IDLE, SHIFT, DONE; encoding free.
REQ-015 IDLE & start=1: latch cnt = min(count_in, W); set sat = (count_in > W); load d_out thermometer of cnt; clear idx and ones_sent; next state SHIFT.
REQ-016 IDLE & start=0: hold all outputs; bit_valid=0, done=0.
REQ-017 SHIFT: bit_valid=1; bit_out = (idx < cnt); idx increments by 1 per cycle from 0.
REQ-018 SHIFT: ones_sent increments on each cycle with bit_out=1, registered (visible next cycle).
REQ-019 SHIFT lasts exactly W cycles (idx 0..W-1); after idx=W-1, next state DONE.
REQ-020 First bit_valid cycle is the cycle after start is sampled; latency start-to-done = W+1 cycles.
REQ-021 DONE: done=1, bit_valid=0, busy=1, for exactly one cycle; then IDLE.
REQ-022 start SHALL be ignored in SHIFT and DONE; no queuing, no abort.
REQ-023 count_in=0: W bits all 0; d_out=0; ones_sent stays 0; done still pulses.
REQ-024 count_in=W: all W bits 1; d_out all ones; ones_sent=W in DONE.
REQ-025 count_in>W (e.g. 9..15 for W=8): treated as W, sat=1.
REQ-026 d_out, cnt, sat remain stable from accept until next accept.
REQ-027 In DONE ones_sent SHALL equal cnt; idx never exceeds W-1 in SHIFT.
REQ-028 bit_out SHALL be 0 whenever bit_valid=0.

Reset
REQ-029 rst=1 asynchronously forces IDLE regardless of state, including mid-SHIFT.
REQ-030 Reset values: d_out=0, bit_out=0, bit_valid=0, busy=0, done=0, sat=0, ones_sent=0, idx=0, cnt=0.
REQ-031 An aborted job produces no done pulse; first start after rst release begins a fresh job.

Verification
REQ-032 W=8, start with count_in=3 -> d_out=8'b0000_0111; bit_out 1,1,1,0,0,0,0,0 over 8 bit_valid cycles; done at cycle 9; ones_sent=3.
REQ-033 count_in=0 and count_in=8 -> all-zero and all-one streams; d_out 8'h00 / 8'hFF; sat=0; ones_sent 0 / 8.
REQ-034 count_in=12 -> sat=1, d_out=8'hFF, 8 ones emitted, ones_sent=8.
REQ-035 start held high continuously with count_in=5 -> jobs back-to-back, one accept per IDLE, each 10 cycles apart, extra starts ignored.
REQ-036 rst asserted at 4th bit of a count_in=6 job -> outputs immediately at reset values, no done; next start with count_in=2 yields 1,1,0,0,0,0,0,0.
REQ-037 Random count_in 0..15 over 1000 jobs -> popcount of streamed bits = min(count_in,8) = ones_sent at done; d_out matches thermometer.
